gru_step_sequencer: RTL and testbench
=====================================

// Module: gru_step_sequencer
// PURPOSE
//  Drives one gru cell over a HIDDEN_SIZE-element hidden vector, one element per accepted beat.
//  Takes six gate pre-activations per element from the upstream MAC array.
//  Skews each operand to the pipeline stage where gru consumes it, and feeds data_hidden_in
//  from an internal hidden-state buffer.
//  Captures data_hidden_out and writes it back to that buffer. Sits between MAC array and gru.
// PARAMETERS
//  DATA_WIDTH  32   operand width, signed Q8.24
//  HIDDEN_SIZE 16   hidden vector length (elements per timestep)
//  CORDIC_LAT  16   cordic D_in->D_out latency, cycles
//  HN_SKEW     17   A->gru_hn offset (CORDIC_LAT+1)
//  IN_SKEW     18   A->gru_in offset (CORDIC_LAT+2)
//  HID_SKEW    18   A->gru_hidden_in offset (CORDIC_LAT+2)
//  OUT_LAT     36   A->gru_hidden_out sample offset (2*CORDIC_LAT+4)
// PORTS
//  clk            in   1   clock
//  rst            in   1   synchronous active-high reset
//  start          in   1   begin one timestep (honoured only in IDLE)
//  clear_h        in   1   zero hidden buffer (honoured only in IDLE)
//  pre_valid      in   1   pre-activation beat valid
//  pre_ready      out  1   =1 in RUN while beats accepted < HIDDEN_SIZE
//  pre_ir/iz/in   in   DW  input-side gate pre-activations
//  pre_hr/hz/hn   in   DW  hidden-side gate pre-activations
//  gru_ir/iz/hr/hz out DW  to gru, aligned at A
//  gru_hn         out  DW  to gru, aligned at A+HN_SKEW
//  gru_in         out  DW  to gru, aligned at A+IN_SKEW
//  gru_hidden_in  out  DW  hbuf[idx], aligned at A+HID_SKEW
//  gru_hidden_out in   DW  from gru
//  h_wb_valid     out  1   writeback strobe
//  h_wb_idx       out  $clog2(HIDDEN_SIZE)  element written
//  h_wb_data      out  DW  value written
//  busy           out  1   state != IDLE
//  done           out  1   1-cycle pulse, timestep complete
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, counters 0, skew-line valids 0.
//    Hidden buffer zeroed. Reset mid-step aborts it: no further writebacks, no done.
//  - FSM: IDLE -start-> RUN -(HIDDEN_SIZE beats accepted)-> DRAIN.
//    DRAIN -(HIDDEN_SIZE writebacks)-> IDLE. done pulses on the cycle of the last h_wb_valid.
//  - start/clear_h outside IDLE ignored. clear_h with start in the same cycle:
//    clear takes effect first, step runs on zeros.
//  - Beat accepted at edge t when pre_valid&pre_ready. It is assigned idx = accepted-count,
//    0..HIDDEN_SIZE-1 in order. A = t+1.
//  - Registered outputs: gru_ir/iz/hr/hz = beat values during cycle A.
//    gru_hn at A+HN_SKEW; gru_in at A+IN_SKEW.
//    gru_hidden_in = hbuf[idx] at A+HID_SKEW (read at that cycle, not at accept).
//  - Each operand carries a valid bit and idx through its delay line.
//    A cycle with delayed valid=0 drives that operand to 0.
//  - gru_hidden_out sampled at end of cycle A+OUT_LAT.
//    Next cycle: h_wb_valid=1, h_wb_idx=idx, h_wb_data=sample, hbuf[idx]=sample.
//  - Bubbles (pre_valid low) propagate as gaps. No spurious writebacks; idx never skips.
//  - Within a step, idx values are distinct, so there is no read/write hazard.
//    The next step cannot start before DRAIN ends, so hidden_in always sees the previous step's result.
//  - No arithmetic on data; values pass bit-exact. Counters saturate at HIDDEN_SIZE.
// TESTING
//  1 rst held 3 cycles, all inputs 1 -> every output 0, pre_ready=0, busy=0.
//  2 start, one beat ir=0x11 hn=0x22 in=0x33, hbuf[0]=0x0100_0000 ->
//    gru_ir=0x11 at A, gru_hn=0x22 at A+17, gru_in=0x33 at A+18, gru_hidden_in=0x0100_0000 at A+18.
//    Zero on all other cycles.
//  3 16 back-to-back beats; bench drives gru_hidden_out=0x1000+k at A_k+36 ->
//    h_wb idx 0..15 with data 0x1000+k. done once, with idx 15. busy low next cycle.
//  4 Same as 3 with pre_valid low every 3rd cycle -> identical writebacks.
//    No h_wb_valid in gaps. pre_ready drops after 16th beat.
//  5 Second step after 3 -> gru_hidden_in for idx k = 0x1000+k. Then clear_h -> next step reads 0.
//  6 rst after 5 beats of a step -> busy=0 next cycle, no h_wb_valid or done for 40 cycles.
//    A fresh start then runs a clean step.

Source files
------------

// File: rtl/gru_step_sequencer.sv
// gru_step_sequencer
//   Feeds one gru cell with a HIDDEN_SIZE-element hidden vector per timestep.
//   Each accepted beat carries six gate pre-activations from the MAC array.
//   The beat is given the next element index. Its operands are delayed to the
//   gru stage that consumes them. The element's previous hidden value is read
//   from an internal buffer. The gru's new hidden value is captured and written
//   back into that buffer.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   start, clear_h        begin a timestep / zero the hidden buffer (IDLE only)
//   pre_valid, pre_ready  beat handshake with the MAC array
//   pre_ir..pre_hn        gate pre-activations (signed Q8.24)
//   gru_ir/iz/hr/hz       operands presented during cycle A (one after accept)
//   gru_hn, gru_in        operands presented at A+HN_SKEW and A+IN_SKEW
//   gru_hidden_in         hidden buffer entry for the element, at A+HID_SKEW
//   gru_hidden_out        gru result, sampled at the end of cycle A+OUT_LAT
//   h_wb_valid/idx/data   writeback strobe, one cycle after the sample
//   busy, done            step in progress / pulse on the last writeback
module gru_step_sequencer #(
  parameter int DATA_WIDTH  = 32,
  parameter int HIDDEN_SIZE = 16,
  parameter int CORDIC_LAT  = 16,
  parameter int HN_SKEW     = CORDIC_LAT + 1,
  parameter int IN_SKEW     = CORDIC_LAT + 2,
  parameter int HID_SKEW    = CORDIC_LAT + 2,
  parameter int OUT_LAT     = 2 * CORDIC_LAT + 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                clear_h,
  input  logic                                pre_valid,
  output logic                                pre_ready,
  input  logic signed [DATA_WIDTH-1:0]        pre_ir,
  input  logic signed [DATA_WIDTH-1:0]        pre_iz,
  input  logic signed [DATA_WIDTH-1:0]        pre_in,
  input  logic signed [DATA_WIDTH-1:0]        pre_hr,
  input  logic signed [DATA_WIDTH-1:0]        pre_hz,
  input  logic signed [DATA_WIDTH-1:0]        pre_hn,
  output logic signed [DATA_WIDTH-1:0]        gru_ir,
  output logic signed [DATA_WIDTH-1:0]        gru_iz,
  output logic signed [DATA_WIDTH-1:0]        gru_hr,
  output logic signed [DATA_WIDTH-1:0]        gru_hz,
  output logic signed [DATA_WIDTH-1:0]        gru_hn,
  output logic signed [DATA_WIDTH-1:0]        gru_in,
  output logic signed [DATA_WIDTH-1:0]        gru_hidden_in,
  input  logic signed [DATA_WIDTH-1:0]        gru_hidden_out,
  output logic                                h_wb_valid,
  output logic [$clog2(HIDDEN_SIZE)-1:0]      h_wb_idx,
  output logic signed [DATA_WIDTH-1:0]        h_wb_data,
  output logic                                busy,
  output logic                                done
);

  localparam int IW = $clog2(HIDDEN_SIZE);
  localparam int CW = $clog2(HIDDEN_SIZE + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(HIDDEN_SIZE);
  localparam logic [CW-1:0] CNT_LAST = CW'(HIDDEN_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0] acc_cnt;
  logic [CW-1:0] wb_cnt;
  logic          accept;
  logic          capture;

  // vld_dly[k]/idx_dly[k] describe the beat whose A cycle was k cycles ago.
  logic          vld_dly [OUT_LAT+1];
  logic [IW-1:0] idx_dly [OUT_LAT+1];

  // Operand delay lines; element k holds the value during cycle A+k.
  logic signed [DATA_WIDTH-1:0] hn_dly [HN_SKEW];
  logic signed [DATA_WIDTH-1:0] in_dly [IN_SKEW];

  logic signed [DATA_WIDTH-1:0] hbuf [HIDDEN_SIZE];

  assign pre_ready = (state == RUN) && (acc_cnt < CNT_FULL);
  assign busy      = (state != IDLE);
  assign accept    = pre_valid && pre_ready;
  assign capture   = vld_dly[OUT_LAT];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (accept && acc_cnt == CNT_LAST) state_nxt = DRAIN;
      // done is high during the last writeback cycle, so busy drops after it
      DRAIN:   if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- control: FSM, counters, valid/index skew line ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      acc_cnt <= '0;
      wb_cnt  <= '0;
      for (int k = 0; k <= OUT_LAT; k++) begin
        vld_dly[k] <= 1'b0;
        idx_dly[k] <= '0;
      end
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        acc_cnt <= '0;
        wb_cnt  <= '0;
      end else begin
        if (accept && acc_cnt != CNT_FULL) acc_cnt <= acc_cnt + 1'b1;
        if (capture && wb_cnt != CNT_FULL) wb_cnt <= wb_cnt + 1'b1;
      end
      vld_dly[0] <= accept;
      idx_dly[0] <= acc_cnt[IW-1:0];
      for (int k = 1; k <= OUT_LAT; k++) begin
        vld_dly[k] <= vld_dly[k-1];
        idx_dly[k] <= idx_dly[k-1];
      end
    end
  end

  // ---- data skew lines: free-running, qualified by vld_dly at the output ----
  always_ff @(posedge clk) begin
    hn_dly[0] <= pre_hn;
    in_dly[0] <= pre_in;
    for (int k = 1; k < HN_SKEW; k++) hn_dly[k] <= hn_dly[k-1];
    for (int k = 1; k < IN_SKEW; k++) in_dly[k] <= in_dly[k-1];
  end

  // ---- output stage: operands to gru, writeback strobe ----
  always_ff @(posedge clk) begin
    if (rst) begin
      gru_ir        <= '0;
      gru_iz        <= '0;
      gru_hr        <= '0;
      gru_hz        <= '0;
      gru_hn        <= '0;
      gru_in        <= '0;
      gru_hidden_in <= '0;
      h_wb_valid    <= 1'b0;
      h_wb_idx      <= '0;
      h_wb_data     <= '0;
      done          <= 1'b0;
    end else begin
      gru_ir <= accept ? pre_ir : '0;
      gru_iz <= accept ? pre_iz : '0;
      gru_hr <= accept ? pre_hr : '0;
      gru_hz <= accept ? pre_hz : '0;
      gru_hn <= vld_dly[HN_SKEW-1] ? hn_dly[HN_SKEW-1] : '0;
      gru_in <= vld_dly[IN_SKEW-1] ? in_dly[IN_SKEW-1] : '0;
      // Buffer read happens here, late, so it sees the previous step's writeback.
      gru_hidden_in <= vld_dly[HID_SKEW-1] ? hbuf[idx_dly[HID_SKEW-1]] : '0;
      h_wb_valid    <= capture;
      h_wb_idx      <= capture ? idx_dly[OUT_LAT] : '0;
      h_wb_data     <= capture ? gru_hidden_out : '0;
      done          <= capture && (wb_cnt == CNT_LAST);
    end
  end

  // ---- hidden-state buffer: clear in IDLE wins over (impossible) writeback ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < HIDDEN_SIZE; k++) hbuf[k] <= '0;
    end else if (state == IDLE && clear_h) begin
      for (int k = 0; k < HIDDEN_SIZE; k++) hbuf[k] <= '0;
    end else if (capture) begin
      hbuf[idx_dly[OUT_LAT]] <= gru_hidden_out;
    end
  end

endmodule

// File: tb/tb_gru_step_sequencer.sv
// Testbench for gru_step_sequencer: directed steps with a per-cycle scoreboard.
module tb_gru_step_sequencer;
  localparam int DW  = 32;
  localparam int HS  = 16;
  localparam int HN  = 17;
  localparam int INS = 18;
  localparam int HID = 18;
  localparam int OL  = 36;

  logic clk = 1'b0;
  logic rst, start, clear_h, pre_valid, pre_ready;
  logic signed [DW-1:0] pre_ir, pre_iz, pre_in, pre_hr, pre_hz, pre_hn;
  logic signed [DW-1:0] gru_ir, gru_iz, gru_hr, gru_hz, gru_hn, gru_in;
  logic signed [DW-1:0] gru_hidden_in, gru_hidden_out, h_wb_data;
  logic                 h_wb_valid, busy, done;
  logic [3:0]           h_wb_idx;

  gru_step_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .clear_h(clear_h),
    .pre_valid(pre_valid), .pre_ready(pre_ready),
    .pre_ir(pre_ir), .pre_iz(pre_iz), .pre_in(pre_in),
    .pre_hr(pre_hr), .pre_hz(pre_hz), .pre_hn(pre_hn),
    .gru_ir(gru_ir), .gru_iz(gru_iz), .gru_hr(gru_hr), .gru_hz(gru_hz),
    .gru_hn(gru_hn), .gru_in(gru_in), .gru_hidden_in(gru_hidden_in),
    .gru_hidden_out(gru_hidden_out),
    .h_wb_valid(h_wb_valid), .h_wb_idx(h_wb_idx), .h_wb_data(h_wb_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          cyc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
  } ev_t;

  ev_t op_q[$], hn_q[$], in_q[$], hid_q[$], wb_q[$], hout_q[$];
  logic [31:0] exp_hbuf [HS];
  logic done_prev = 1'b0;

  function automatic ev_t mk(input int c, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] cc, input logic [31:0] d);
    ev_t e;
    e.cyc = c; e.a = a; e.b = b; e.c = cc; e.d = d;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every cycle, each output either matches the event due now or is 0.
  always @(negedge clk) begin
    ev_t e;
    if (op_q.size() > 0 && op_q[0].cyc == cyc) begin
      e = op_q.pop_front();
      check("gru_ir", gru_ir, e.a);
      check("gru_iz", gru_iz, e.b);
      check("gru_hr", gru_hr, e.c);
      check("gru_hz", gru_hz, e.d);
    end else begin
      check("gru_ir_idle", gru_ir, 0);
      check("gru_iz_idle", gru_iz, 0);
      check("gru_hr_idle", gru_hr, 0);
      check("gru_hz_idle", gru_hz, 0);
    end
    if (hn_q.size() > 0 && hn_q[0].cyc == cyc) begin
      e = hn_q.pop_front();
      check("gru_hn", gru_hn, e.a);
    end else check("gru_hn_idle", gru_hn, 0);
    if (in_q.size() > 0 && in_q[0].cyc == cyc) begin
      e = in_q.pop_front();
      check("gru_in", gru_in, e.a);
    end else check("gru_in_idle", gru_in, 0);
    if (hid_q.size() > 0 && hid_q[0].cyc == cyc) begin
      e = hid_q.pop_front();
      check("gru_hidden_in", gru_hidden_in, e.a);
    end else check("gru_hidden_in_idle", gru_hidden_in, 0);
    if (wb_q.size() > 0 && wb_q[0].cyc == cyc) begin
      e = wb_q.pop_front();
      check("h_wb_valid", 32'(h_wb_valid), 1);
      check("h_wb_idx", 32'(h_wb_idx), e.a);
      check("h_wb_data", h_wb_data, e.b);
      check("done", 32'(done), e.c);
    end else begin
      check("h_wb_valid_spurious", 32'(h_wb_valid), 0);
      check("done_spurious", 32'(done), 0);
    end
    if (done_prev) check("busy_after_done", 32'(busy), 0);
    done_prev <= done;
  end

  // gru model stand-in: drives the scheduled result only in its sample cycle.
  always @(posedge clk) begin
    ev_t t;
    #1;
    while (hout_q.size() > 0 && hout_q[0].cyc < cyc) t = hout_q.pop_front();
    if (hout_q.size() > 0 && hout_q[0].cyc == cyc) begin
      t = hout_q.pop_front();
      gru_hidden_out = t.a;
    end else begin
      gru_hidden_out = 32'hDEAD_0000 ^ 32'(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0; clear_h = 1'b0; pre_valid = 1'b0;
  endtask

  task automatic do_start(input logic clr);
    tick();
    start = 1'b1;
    clear_h = clr;
    if (clr) for (int i = 0; i < HS; i++) exp_hbuf[i] = '0;
  endtask

  // Drive one beat for element idx (called right after tick); A is next cycle.
  task automatic beat(input int idx, input logic [31:0] ir, input logic [31:0] iz,
                      input logic [31:0] hr, input logic [31:0] hz, input logic [31:0] hn,
                      input logic [31:0] inn, input logic [31:0] hout);
    int a;
    check("pre_ready_run", 32'(pre_ready), 1);
    pre_valid = 1'b1;
    pre_ir = ir; pre_iz = iz; pre_hr = hr; pre_hz = hz; pre_hn = hn; pre_in = inn;
    a = cyc + 1;
    op_q.push_back(mk(a, ir, iz, hr, hz));
    hn_q.push_back(mk(a + HN, hn, 0, 0, 0));
    in_q.push_back(mk(a + INS, inn, 0, 0, 0));
    hid_q.push_back(mk(a + HID, exp_hbuf[idx], 0, 0, 0));
    hout_q.push_back(mk(a + OL, hout, 0, 0, 0));
    wb_q.push_back(mk(a + OL + 1, 32'(idx), hout, (idx == HS - 1) ? 32'd1 : 32'd0, 0));
    exp_hbuf[idx] = hout;
  endtask

  task automatic do_beats(input int first, input int count, input bit gaps,
                          input logic [31:0] dbase, input logic [31:0] hbase);
    int n = 0;
    int k = first;
    while (k < first + count) begin
      tick();
      n++;
      if (gaps && (n % 3 == 0)) continue;
      beat(k, dbase + 32'(k * 16 + 1), dbase + 32'(k * 16 + 2), dbase + 32'(k * 16 + 3),
           dbase + 32'(k * 16 + 4), dbase + 32'(k * 16 + 5), dbase + 32'(k * 16 + 6),
           hbase + 32'(k));
      k++;
    end
    tick();
  endtask

  task automatic after_last_beat();
    check("pre_ready_drain", 32'(pre_ready), 0);
    check("busy_drain", 32'(busy), 1);
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (wb_q.size() == 0 && hid_q.size() == 0 && in_q.size() == 0 && hn_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("drain_within_bound", 32'(ok), 1);
    tick();
    tick();
    check("busy_idle", 32'(busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < HS; i++) exp_hbuf[i] = '0;
    rst = 1'b1; start = 1'b1; clear_h = 1'b1; pre_valid = 1'b1;
    pre_ir = '1; pre_iz = '1; pre_in = '1; pre_hr = '1; pre_hz = '1; pre_hn = '1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pre_ready", 32'(pre_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_h_wb_valid", 32'(h_wb_valid), 0);
    check("rst_h_wb_idx", 32'(h_wb_idx), 0);
    check("rst_h_wb_data", h_wb_data, 0);
    check("rst_gru_ir", gru_ir, 0);
    check("rst_gru_hn", gru_hn, 0);
    check("rst_gru_in", gru_in, 0);
    check("rst_gru_hidden_in", gru_hidden_in, 0);
    rst = 1'b0; start = 1'b0; clear_h = 1'b0; pre_valid = 1'b0;
    pre_ir = '0; pre_iz = '0; pre_in = '0; pre_hr = '0; pre_hz = '0; pre_hn = '0;

    // Load hbuf[k] = 0x0100_0000 + k.
    do_start(1'b0);
    do_beats(0, HS, 1'b0, 32'hA000_0000, 32'h0100_0000);
    after_last_beat();
    wait_drain();

    // Single spaced beat: hidden_in for idx 0 must be 0x0100_0000.
    do_start(1'b0);
    tick();
    beat(0, 32'h11, 32'h0, 32'h0, 32'h0, 32'h22, 32'h33, 32'h2000);
    repeat (30) tick();
    do_beats(1, HS - 1, 1'b0, 32'hB000_0000, 32'h2000);
    after_last_beat();
    wait_drain();

    // Back-to-back step, results 0x1000+k.
    do_start(1'b0);
    do_beats(0, HS, 1'b0, 32'hC000_0000, 32'h1000);
    after_last_beat();
    wait_drain();

    // Bubble every third cycle; reads back 0x1000+k, writes 0x1000+k again.
    do_start(1'b0);
    do_beats(0, HS, 1'b1, 32'h7000_0000, 32'h1000);
    after_last_beat();
    wait_drain();

    // Clear together with start: step reads zeros.
    do_start(1'b1);
    do_beats(0, HS, 1'b0, 32'h5000_0000, 32'h3000);
    after_last_beat();
    wait_drain();

    // Abort after 5 beats; nothing further may come out.
    do_start(1'b0);
    do_beats(0, 5, 1'b0, 32'h6000_0000, 32'h5000);
    rst = 1'b1;
    while (op_q.size() > 0 && op_q[op_q.size()-1].cyc > cyc) op_q.pop_back();
    while (hn_q.size() > 0 && hn_q[hn_q.size()-1].cyc > cyc) hn_q.pop_back();
    while (in_q.size() > 0 && in_q[in_q.size()-1].cyc > cyc) in_q.pop_back();
    while (hid_q.size() > 0 && hid_q[hid_q.size()-1].cyc > cyc) hid_q.pop_back();
    while (wb_q.size() > 0 && wb_q[wb_q.size()-1].cyc > cyc) wb_q.pop_back();
    while (hout_q.size() > 0 && hout_q[hout_q.size()-1].cyc > cyc) hout_q.pop_back();
    for (int i = 0; i < HS; i++) exp_hbuf[i] = '0;
    tick();
    check("abort_busy", 32'(busy), 0);
    check("abort_pre_ready", 32'(pre_ready), 0);
    repeat (40) tick();

    // Fresh step after abort: buffer was zeroed by reset.
    do_start(1'b0);
    do_beats(0, HS, 1'b0, 32'h9000_0000, 32'h4000);
    after_last_beat();
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
